act_skew_feeder: RTL and testbench



---
 rtl/tpu_pkg.sv | 17 +
 rtl/skew_delay_line.sv | 30 +++
 rtl/act_skew_feeder.sv | 90 +++++++++
 tb/tb_act_skew_feeder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared sizes and types for the activation front end of the systolic array
package tpu_pkg;

   localparam int ARRAY_N = 32;
   localparam int ACT_W   = 16;
   localparam int DRAIN_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

   typedef logic [ACT_W-1:0] act_t;
   typedef act_t act_vec_t [ARRAY_N];

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - enable-gated shift register delaying one lane by DEPTH advancing cycles
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int ACT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [ACT_W-1:0] d_i,
   output logic [ACT_W-1:0] q_o
);

   logic [ACT_W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else if (en_i) begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// rtl/act_skew_feeder.sv - accepts activation vectors, skews lane k by k cycles and drains with zeros
module act_skew_feeder
   import tpu_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  act_vec_t act_i,
   input  logic     valid_i,
   input  logic     last_i,
   output logic     ready_o,
   input  logic     stall_i,
   input  logic     start_i,
   output act_vec_t act_o,
   output logic     compute_o,
   output logic     busy_o,
   output logic     done_o
);

   feeder_state_t      state_q, state_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic               adv;
   logic               accept;
   act_vec_t           head;

   assign adv       = (state_q != IDLE) && !stall_i;
   assign ready_o   = (state_q == STREAM) && !stall_i;
   assign accept    = valid_i && ready_o;
   assign compute_o = adv;
   assign busy_o    = (state_q != IDLE);

   // Bubbles and drain cycles push zeros so the array never sees stale data.
   for (genvar k = 0; k < ARRAY_N; k++) begin : g_lane
      assign head[k] = accept ? act_i[k] : '0;

      skew_delay_line #(
         .DEPTH (k + 1),
         .ACT_W (ACT_W)
      ) u_lane (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .en_i  (adv),
         .d_i   (head[k]),
         .q_o   (act_o[k])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      done_o      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (accept && last_i) begin
               state_d     = DRAIN;
               drain_cnt_d = DRAIN_W'(ARRAY_N - 1);
            end
         end
         DRAIN: begin
            // The last vector reaches the final lane after ARRAY_N advancing cycles.
            if (adv) begin
               if (drain_cnt_q == '0) begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end else begin
                  drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_act_skew_feeder.sv
// tb/tb_act_skew_feeder.sv - self-checking bench for act_skew_feeder
module tb_act_skew_feeder;
   import tpu_pkg::*;

   logic     clk_i = 1'b0;
   logic     rst_i, valid_i, last_i, stall_i, start_i;
   act_vec_t act_i, act_o;
   logic     ready_o, compute_o, busy_o, done_o;

   always #5 clk_i = ~clk_i;

   act_skew_feeder dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .act_i     (act_i),
      .valid_i   (valid_i),
      .last_i    (last_i),
      .ready_o   (ready_o),
      .stall_i   (stall_i),
      .start_i   (start_i),
      .act_o     (act_o),
      .compute_o (compute_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   int total = 0;
   int bad   = 0;

   // reference: history of lane-head vectors, one per advancing cycle, newest at back
   act_vec_t hist[$];
   int       m_mode = 0;   // 0 idle, 1 stream, 2 drain
   int       m_left = 0;   // advancing cycles still owed after the last vector
   logic     saw_done;

   typedef struct {
      logic rst, start, valid, last, stall;
      logic e_ready, e_busy, e_comp, e_done;
   } row_t;
   row_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic act_t lane_exp(input int k);
      int idx;
      idx = hist.size() - 1 - k;
      if (idx >= 0) return hist[idx][k];
      return '0;
   endfunction

   task automatic half_a();
      logic e_ready, e_adv, e_done;
      int   badk;
      @(negedge clk_i);
      e_ready = (m_mode == 1) && !stall_i;
      e_adv   = (m_mode != 0) && !stall_i;
      e_done  = (m_mode == 2) && e_adv && (m_left == 1);
      saw_done = (done_o === 1'b1);
      chk("ready", 32'(ready_o), 32'(e_ready));
      chk("compute", 32'(compute_o), 32'(e_adv));
      chk("busy", 32'(busy_o), 32'(m_mode != 0));
      chk("done", 32'(done_o), 32'(e_done));
      badk = -1;
      for (int k = 0; k < ARRAY_N; k++) begin
         if (act_o[k] !== lane_exp(k) && badk < 0) badk = k;
      end
      total++;
      if (badk >= 0) begin
         bad++;
         $display("FAIL act_lane%0d actual=%0h required=%0h t=%0t", badk, act_o[badk], lane_exp(badk), $time);
      end
   endtask

   task automatic half_b();
      logic     e_ready, e_adv, acc;
      act_vec_t h;
      @(posedge clk_i);
      e_ready = (m_mode == 1) && !stall_i;
      e_adv   = (m_mode != 0) && !stall_i;
      acc     = valid_i && e_ready;
      if (rst_i) begin
         hist.delete();
         m_mode = 0;
         m_left = 0;
      end else begin
         if (e_adv) begin
            for (int k = 0; k < ARRAY_N; k++) h[k] = acc ? act_i[k] : '0;
            hist.push_back(h);
            if (hist.size() > ARRAY_N) void'(hist.pop_front());
         end
         case (m_mode)
            0: if (start_i) m_mode = 1;
            1: if (acc && last_i) begin
               m_mode = 2;
               m_left = ARRAY_N;
            end
            default: if (e_adv) begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
         endcase
      end
      #1;
   endtask

   task automatic cyc();
      half_a();
      half_b();
   endtask

   task automatic set_in(input logic r, input logic s, input logic v, input logic l, input logic st);
      rst_i = r; start_i = s; valid_i = v; last_i = l; stall_i = st;
   endtask

   task automatic rand_act();
      for (int k = 0; k < ARRAY_N; k++) act_i[k] = act_t'($urandom);
   endtask

   task automatic seq_act(input int base);
      for (int k = 0; k < ARRAY_N; k++) act_i[k] = act_t'(base + k);
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      saw_done = 1'b0;
      while (!saw_done && n < max) begin
         cyc();
         n++;
      end
   endtask

   int n;

   initial begin
      set_in(1, 0, 0, 0, 0);
      seq_act(0);
      half_b();
      half_b();

      // control table, ARRAY_N = 32
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].rst, tbl[i].start, tbl[i].valid, tbl[i].last, tbl[i].stall);
         rand_act();
         @(negedge clk_i);
         chk($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_compute", i), 32'(compute_o), 32'(tbl[i].e_comp));
         chk($sformatf("tbl%0d_done", i), 32'(done_o), 32'(tbl[i].e_done));
         half_b();
      end

      // single vector, lane k carries k+1
      set_in(0, 1, 0, 0, 0); cyc();
      set_in(0, 0, 1, 1, 0); seq_act(1); cyc();
      set_in(0, 0, 0, 0, 0); wait_done(100, n);
      chk("t1_done_latency", 32'(n), 32'd32);
      cyc();
      chk("t1_idle_busy", 32'(busy_o), 32'd0);

      // four back-to-back vectors, then a tile with a two-cycle bubble
      set_in(0, 1, 0, 0, 0); cyc();
      for (int v = 0; v < 4; v++) begin
         set_in(0, 0, 1, v == 3, 0); seq_act(100 * v); cyc();
      end
      set_in(0, 0, 0, 0, 0); wait_done(100, n);
      chk("t2_done_latency", 32'(n), 32'd32);
      set_in(0, 1, 0, 0, 0); cyc();
      set_in(0, 0, 1, 0, 0); seq_act(500); cyc();
      set_in(0, 0, 0, 0, 0); cyc(); cyc();
      set_in(0, 0, 1, 1, 0); seq_act(700); cyc();
      set_in(0, 0, 0, 0, 0); wait_done(100, n);
      chk("t3_done_latency", 32'(n), 32'd32);

      // three stall cycles in DRAIN push done out by three
      set_in(0, 1, 0, 0, 0); cyc();
      set_in(0, 0, 1, 1, 0); rand_act(); cyc();
      set_in(0, 0, 0, 0, 0); repeat (10) cyc();
      set_in(0, 0, 0, 0, 1); repeat (3) cyc();
      set_in(0, 0, 0, 0, 0); wait_done(100, n);
      chk("t4_done_latency", 32'(13 + n), 32'd35);

      // reset five cycles into DRAIN: no done, then a clean tile
      set_in(0, 1, 0, 0, 0); cyc();
      set_in(0, 0, 1, 1, 0); rand_act(); cyc();
      set_in(0, 0, 0, 0, 0); repeat (5) cyc();
      set_in(1, 0, 0, 0, 0); cyc();
      set_in(0, 0, 0, 0, 0); wait_done(40, n);
      chk("t5_no_done", 32'(saw_done), 32'd0);
      set_in(0, 1, 0, 0, 0); cyc();
      set_in(0, 0, 1, 1, 0); rand_act(); cyc();
      set_in(0, 0, 0, 0, 0); wait_done(100, n);
      chk("t5_clean_latency", 32'(n), 32'd32);

      // random traffic against the reference
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
                $urandom_range(0, 5) == 0);
         rand_act();
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
